// File: rtl/logic_result_stage_if.sv
// rtl/logic_result_stage_if.sv - handshake bundle between logic units, result stage and consumer
interface logic_result_stage_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] or_in;
    logic [WIDTH-1:0] nor_in;
    logic [WIDTH-1:0] xor_in;
    logic [WIDTH-1:0] xnor_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             parity;
    logic [CNT_W-1:0] xfer_count;

    modport master (
        output in_valid, op, or_in, nor_in, xor_in, xnor_in, out_ready,
        input  in_ready, out_valid, result, zero, neg, parity, xfer_count
    );

    modport slave (
        input  in_valid, op, or_in, nor_in, xor_in, xnor_in, out_ready,
        output in_ready, out_valid, result, zero, neg, parity, xfer_count
    );
endinterface

// File: rtl/logic_result_stage.sv
// rtl/logic_result_stage.sv - opcode-selected logic result capture into a 2-entry output buffer
module logic_result_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_result_stage_if.slave  bus
);
    localparam int EW = WIDTH + 3;

    logic [EW-1:0]    mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [CNT_W-1:0] xfer_q;
    logic [WIDTH-1:0] sel;
    logic [EW-1:0]    entry;
    logic             push;
    logic             pop;

    always_comb begin
        sel = bus.or_in;
        case (bus.op)
            2'b00:   sel = bus.or_in;
            2'b01:   sel = bus.nor_in;
            2'b10:   sel = bus.xor_in;
            default: sel = bus.xnor_in;
        endcase
    end

    // Flags are computed at capture time so the output side is purely registered.
    assign entry = {^sel, sel[WIDTH-1], (sel == '0), sel};

    assign bus.in_ready  = !rst && (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign {bus.parity, bus.neg, bus.zero, bus.result} = mem[rd_ptr];
    assign bus.xfer_count = xfer_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            xfer_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                xfer_q <= xfer_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_result_stage.sv
// tb/tb_logic_result_stage.sv - directed vector bench for logic_result_stage
module tb_logic_result_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic_result_stage_if #(.WIDTH(16), .CNT_W(8)) bus ();

    logic_result_stage #(.WIDTH(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a, b, c, d;
        logic [15:0] r;
        logic        z, n, p;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        bus.in_valid = v;
        bus.op       = o;
        bus.or_in    = a;
        bus.nor_in   = b;
        bus.xor_in   = c;
        bus.xnor_in  = d;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0]  expcnt;
        logic [15:0] prev;

        vecs[0] = '{2'b10, 16'h0FFF, 16'hF000, 16'h0FF0, 16'hF00F, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 16'h0FFF, 16'hF000, 16'h0FF0, 16'hF00F, 16'hF000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{2'b11, 16'h0FFF, 16'hF000, 16'h0FF0, 16'hF00F, 16'hF00F, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 16'h0FFF, 16'hF000, 16'h0FF0, 16'hF00F, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2'b00, 16'h0000, 16'hFFFF, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 16'h0000, 16'h0000, 16'h0007, 16'h0000, 16'h0007, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{2'b01, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1};

        set_in(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        bus.out_ready = 1'b0;

        #12;
        chk("reset_in_ready",   32'(bus.in_ready), 32'd0);
        chk("reset_out_valid",  32'(bus.out_valid), 32'd0);
        chk("reset_result",     32'(bus.result), 32'd0);
        chk("reset_flags",      32'({bus.zero, bus.neg, bus.parity}), 32'd0);
        chk("reset_xfer_count", 32'(bus.xfer_count), 32'd0);
        rst = 1'b0;
        step();
        chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

        expcnt = 8'd0;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
            step();
            set_in(1'b0, ~vecs[i].op, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hFACE);
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_result", i), 32'(bus.result), 32'(vecs[i].r));
            chk($sformatf("vec%0d_zero", i), 32'(bus.zero), 32'(vecs[i].z));
            chk($sformatf("vec%0d_neg", i), 32'(bus.neg), 32'(vecs[i].n));
            chk($sformatf("vec%0d_parity", i), 32'(bus.parity), 32'(vecs[i].p));
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            expcnt++;
            chk($sformatf("vec%0d_drained", i), 32'(bus.out_valid), 32'd0);
            chk($sformatf("vec%0d_count", i), 32'(bus.xfer_count), 32'(expcnt));
        end

        // Backpressure: two entries fill the buffer, third is held upstream.
        do_reset();
        set_in(1'b1, 2'b00, 16'h1111, 16'h0, 16'h0, 16'h0);
        step();
        set_in(1'b1, 2'b00, 16'h2222, 16'h0, 16'h0, 16'h0);
        step();
        chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
        set_in(1'b1, 2'b00, 16'h3333, 16'h0, 16'h0, 16'h0);
        step();
        chk("bp_hold_result", 32'(bus.result), 32'h1111);
        chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_reopen_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_second", 32'(bus.result), 32'h2222);
        step();
        bus.in_valid = 1'b0;
        chk("bp_third", 32'(bus.result), 32'h3333);
        chk("bp_third_valid", 32'(bus.out_valid), 32'd1);
        step();
        bus.out_ready = 1'b0;
        chk("bp_empty", 32'(bus.out_valid), 32'd0);
        chk("bp_count", 32'(bus.xfer_count), 32'd3);

        // Streaming at occupancy 1: one result per cycle.
        do_reset();
        bus.out_ready = 1'b1;
        set_in(1'b1, 2'b10, 16'h0, 16'h0, 16'h0100, 16'h0);
        step();
        prev = 16'h0100;
        for (int i = 1; i <= 10; i++) begin
            set_in(1'b1, 2'b10, 16'h0, 16'h0, 16'(16'h0100 + i), 16'h0);
            chk($sformatf("stream%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stream%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            chk($sformatf("stream%0d_result", i), 32'(bus.result), 32'(prev));
            chk($sformatf("stream%0d_count", i), 32'(bus.xfer_count), 32'(i - 1));
            step();
            prev = 16'(16'h0100 + i);
        end
        bus.in_valid = 1'b0;
        chk("stream_last", 32'(bus.result), 32'h010A);
        step();
        bus.out_ready = 1'b0;
        chk("stream_final_count", 32'(bus.xfer_count), 32'd11);

        // Asynchronous reset with two entries buffered and a nonzero count.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 2'b00, 16'h00AA, 16'h0, 16'h0, 16'h0);
            step();
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
        set_in(1'b1, 2'b00, 16'h5555, 16'h0, 16'h0, 16'h0);
        step();
        set_in(1'b1, 2'b00, 16'h6666, 16'h0, 16'h0, 16'h0);
        step();
        bus.in_valid = 1'b0;
        chk("mid_pre_count", 32'(bus.xfer_count), 32'd5);
        chk("mid_pre_full", 32'(bus.in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_result", 32'(bus.result), 32'd0);
        chk("mid_count", 32'(bus.xfer_count), 32'd0);
        chk("mid_in_ready", 32'(bus.in_ready), 32'd0);
        #1 rst = 1'b0;
        step();
        chk("mid_release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_release_empty", 32'(bus.out_valid), 32'd0);

        // Counter wrap after 256 handshakes.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            set_in(1'b1, 2'b00, 16'(i), 16'h0, 16'h0, 16'h0);
            step();
            bus.in_valid = 1'b0;
            step();
        end
        chk("wrap_255", 32'(bus.xfer_count), 32'hFF);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("wrap_256", 32'(bus.xfer_count), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
